// File: rtl/pkt_byte_serializer_pkg.sv
// Shared types and constants for the packet-word to byte-stream serializer.
// Flag encodings, framing bytes, state encoding and small word-decoding helpers.
package pkt_byte_serializer_pkg;

  localparam int PKT_WORD_W = 134;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  typedef enum logic [1:0] {
    FLAG_SINGLE = 2'b00,
    FLAG_HEAD   = 2'b01,
    FLAG_TAIL   = 2'b10,
    FLAG_MID    = 2'b11
  } flag_e;

  typedef struct packed {
    flag_e        flag;
    logic [3:0]   inv_cnt;
    logic [127:0] payload;
  } pkt_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_IFG
  } state_e;

  function automatic logic is_start(input flag_e f);
    return (f == FLAG_HEAD) || (f == FLAG_SINGLE);
  endfunction

  function automatic logic is_end(input flag_e f);
    return (f == FLAG_TAIL) || (f == FLAG_SINGLE);
  endfunction

  // Byte 0 sits in the most significant byte lane of the payload.
  function automatic logic [7:0] word_byte(input logic [127:0] p, input logic [3:0] idx);
    return p[{~idx, 3'b000} +: 8];
  endfunction

  function automatic logic [3:0] last_idx(input pkt_word_t w);
    return is_end(w.flag) ? (4'd15 - w.inv_cnt) : 4'd15;
  endfunction

  function automatic logic first_is_last(input pkt_word_t w);
    return is_end(w.flag) && (last_idx(w) == 4'd0);
  endfunction

endpackage

// File: rtl/pkt_byte_serializer_if.sv
// Packet word input, byte stream output and status pulses of the serializer.
// master drives packet words and consumes bytes; slave is the serializer.
interface pkt_byte_serializer_if;
  import pkt_byte_serializer_pkg::*;

  logic [PKT_WORD_W-1:0] iv_pkt_data;
  logic                  i_pkt_data_wr;
  logic                  o_pkt_data_ready;
  logic [7:0]            ov_pkt_data;
  logic                  o_pkt_data_wr;
  logic                  o_frame_done_pulse;
  logic                  o_format_err_pulse;
  logic                  o_stall_pulse;

  modport master (
    output iv_pkt_data, i_pkt_data_wr,
    input  o_pkt_data_ready, ov_pkt_data, o_pkt_data_wr,
    input  o_frame_done_pulse, o_format_err_pulse, o_stall_pulse
  );

  modport slave (
    input  iv_pkt_data, i_pkt_data_wr,
    output o_pkt_data_ready, ov_pkt_data, o_pkt_data_wr,
    output o_frame_done_pulse, o_format_err_pulse, o_stall_pulse
  );

endinterface

// File: rtl/pkt_byte_serializer.sv
// Serializes 134-bit packet words into a byte stream with optional preamble/SFD
// and a minimum inter-frame gap; accepts one word per 16 bytes, gap-free in a frame.
module pkt_byte_serializer
  import pkt_byte_serializer_pkg::*;
#(
  parameter bit PREAMBLE_EN = 1'b1,
  parameter int IFG_BYTES   = 12
) (
  input logic i_clk,
  input logic i_rst,
  pkt_byte_serializer_if.slave bus
);

  localparam logic [7:0] IFG_LOAD = 8'(IFG_BYTES - 1);

  state_e     state;
  pkt_word_t  held;
  logic [3:0] byte_idx;
  logic [2:0] pre_cnt;
  logic [7:0] ifg_cnt;
  logic       consumed;
  logic       stalled;
  logic       armed;

  logic [7:0] data_q;
  logic       wr_q;
  logic       done_q;
  logic       err_q;
  logic       stall_q;

  pkt_word_t  in_word;
  logic [3:0] nxt_idx;
  logic       ready;
  logic       accept;

  assign in_word = pkt_word_t'(bus.iv_pkt_data);
  assign nxt_idx = byte_idx + 4'd1;

  // armed keeps ready low until the first clock after reset release.
  always_comb begin
    ready = 1'b0;
    if (armed) begin
      case (state)
        ST_IDLE: ready = 1'b1;
        ST_DATA: ready = consumed || (!is_end(held.flag) && (byte_idx == 4'd15));
        default: ready = 1'b0;
      endcase
    end
  end

  assign accept = bus.i_pkt_data_wr && ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      held     <= '0;
      byte_idx <= '0;
      pre_cnt  <= '0;
      ifg_cnt  <= '0;
      consumed <= 1'b0;
      stalled  <= 1'b0;
      armed    <= 1'b0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      armed   <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_start(in_word.flag)) begin
              held     <= in_word;
              stalled  <= 1'b0;
              consumed <= 1'b0;
              wr_q     <= 1'b1;
              if (PREAMBLE_EN) begin
                state   <= ST_PRE;
                pre_cnt <= '0;
                data_q  <= PREAMBLE_BYTE;
              end else begin
                state    <= ST_DATA;
                byte_idx <= '0;
                data_q   <= word_byte(in_word.payload, 4'd0);
                done_q   <= first_is_last(in_word);
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        ST_PRE: begin
          if (pre_cnt == 3'd7) begin
            state    <= ST_DATA;
            byte_idx <= '0;
            data_q   <= word_byte(held.payload, 4'd0);
            done_q   <= first_is_last(held);
          end else begin
            pre_cnt <= pre_cnt + 3'd1;
            data_q  <= (pre_cnt == 3'd6) ? SFD_BYTE : PREAMBLE_BYTE;
          end
        end

        // A start word inside a frame aborts it: no done pulse, straight to the gap.
        ST_DATA: begin
          if (accept) begin
            if (is_start(in_word.flag)) begin
              err_q   <= 1'b1;
              wr_q    <= 1'b0;
              state   <= ST_IFG;
              ifg_cnt <= IFG_LOAD;
            end else begin
              held     <= in_word;
              consumed <= 1'b0;
              byte_idx <= '0;
              wr_q     <= 1'b1;
              data_q   <= word_byte(in_word.payload, 4'd0);
              done_q   <= first_is_last(in_word);
            end
          end else if (consumed) begin
            wr_q <= 1'b0;
          end else if (is_end(held.flag) && (byte_idx == last_idx(held))) begin
            wr_q    <= 1'b0;
            state   <= ST_IFG;
            ifg_cnt <= IFG_LOAD;
          end else if (byte_idx == 4'd15) begin
            consumed <= 1'b1;
            wr_q     <= 1'b0;
            stalled  <= 1'b1;
            stall_q  <= !stalled;
          end else begin
            byte_idx <= nxt_idx;
            data_q   <= word_byte(held.payload, nxt_idx);
            done_q   <= is_end(held.flag) && (nxt_idx == last_idx(held));
          end
        end

        ST_IFG: begin
          if (ifg_cnt == 8'd0) begin
            state <= ST_IDLE;
          end else begin
            ifg_cnt <= ifg_cnt - 8'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_pkt_data_ready   = ready;
  assign bus.ov_pkt_data        = data_q;
  assign bus.o_pkt_data_wr      = wr_q;
  assign bus.o_frame_done_pulse = done_q;
  assign bus.o_format_err_pulse = err_q;
  assign bus.o_stall_pulse      = stall_q;

endmodule

// File: tb/tb_pkt_byte_serializer.sv
// Scoreboard bench for pkt_byte_serializer: the driver queues expected bytes on
// acceptance, a negedge monitor pops and compares every emitted byte.
module tb_pkt_byte_serializer;
  import pkt_byte_serializer_pkg::*;

  localparam int IFG = 12;

  typedef struct {
    logic [7:0] data;
    logic       done;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  pkt_byte_serializer_if sif();

  pkt_byte_serializer #(.PREAMBLE_EN(1'b1), .IFG_BYTES(IFG)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (sif)
  );

  always #4 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int done_total = 0, err_total = 0, stall_total = 0, gap_total = 0;
  int first_byte_cyc = 0, last_byte_cyc = 0, done_cyc = 0;
  bit in_frame = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [133:0] mkWord(input logic [1:0] flag, input logic [3:0] n, input logic [7:0] base);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) p[127-8*i -: 8] = base + 8'(i);
    return {flag, n, p};
  endfunction

  task automatic pushBytes(input logic [133:0] w);
    logic [1:0] f;
    int nv, cnt;
    bit ends, starts;
    f = w[133:132];
    nv = int'(w[131:128]);
    ends = (f == 2'b10) || (f == 2'b00);
    starts = (f == 2'b01) || (f == 2'b00);
    cnt = ends ? 16 - nv : 16;
    if (starts) begin
      for (int i = 0; i < 7; i++) sb.push_back('{8'h55, 1'b0});
      sb.push_back('{8'hD5, 1'b0});
    end
    for (int i = 0; i < cnt; i++) sb.push_back('{w[127-8*i -: 8], ends && (i == cnt - 1)});
  endtask

  // Waits for ready, optionally holds off 'delay' cycles, then presents one word.
  task automatic applyStimulus(input logic [133:0] w, input int delay, input bit expect_err, output int acc_cyc);
    int waited;
    waited = 0;
    acc_cyc = -1;
    @(negedge i_clk);
    sif.i_pkt_data_wr = 1'b0;
    while (!sif.o_pkt_data_ready && waited < 500) begin
      @(negedge i_clk);
      waited++;
    end
    if (!sif.o_pkt_data_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: ready stayed 0, required 1 within 500 cycles");
      return;
    end
    repeat (delay) @(negedge i_clk);
    sif.iv_pkt_data = w;
    sif.i_pkt_data_wr = 1'b1;
    acc_cyc = cyc;
    if (!expect_err) pushBytes(w);
    @(posedge i_clk);
    #1 sif.i_pkt_data_wr = 1'b0;
  endtask

  task automatic waitIdle();
    int waited;
    waited = 0;
    @(negedge i_clk);
    while (!(sb.size() == 0 && sif.o_pkt_data_ready) && waited < 3000) begin
      @(negedge i_clk);
      waited++;
    end
    if (waited >= 3000) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: %0d bytes still expected, ready=%0b", sb.size(), sif.o_pkt_data_ready);
    end
  endtask

  task automatic waitReady(output int rdy_cyc);
    int waited;
    waited = 0;
    rdy_cyc = -1;
    @(negedge i_clk);
    while (!sif.o_pkt_data_ready && waited < 500) begin
      @(negedge i_clk);
      waited++;
    end
    if (sif.o_pkt_data_ready) rdy_cyc = cyc;
  endtask

  // Monitor: pops the scoreboard on every valid byte and tracks frame-level events.
  always @(negedge i_clk) begin
    if (i_rst) begin
      in_frame = 1'b0;
    end else begin
      if (sif.o_format_err_pulse) begin
        err_total++;
        in_frame = 1'b0;
      end
      if (sif.o_stall_pulse) stall_total++;
      if (sif.o_pkt_data_wr) begin
        last_byte_cyc = cyc;
        if (!in_frame) begin
          in_frame = 1'b1;
          first_byte_cyc = cyc;
        end
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", sif.ov_pkt_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("byte", 64'(sif.ov_pkt_data), 64'(e.data));
          checkOutput("done_with_byte", 64'(sif.o_frame_done_pulse), 64'(e.done));
        end
      end else begin
        if (in_frame) gap_total++;
        if (sif.o_frame_done_pulse) checkOutput("done_without_wr", 64'(sif.o_frame_done_pulse), 64'd0);
      end
      if (sif.o_frame_done_pulse) begin
        done_total++;
        done_cyc = cyc;
        in_frame = 1'b0;
      end
    end
  end

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_data"}, 64'(sif.ov_pkt_data), 64'd0);
    checkOutput({tag, "_wr"}, 64'(sif.o_pkt_data_wr), 64'd0);
    checkOutput({tag, "_ready"}, 64'(sif.o_pkt_data_ready), 64'd0);
    checkOutput({tag, "_pulses"},
                64'({sif.o_frame_done_pulse, sif.o_format_err_pulse, sif.o_stall_pulse}), 64'd0);
  endtask

  initial begin
    int t, r, d0, e0, s0, g0;
    sif.iv_pkt_data = '0;
    sif.i_pkt_data_wr = 1'b0;
    i_rst = 1'b1;

    repeat (3) @(negedge i_clk);
    checkQuiet("reset");
    i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("ready_after_reset", 64'(sif.o_pkt_data_ready), 64'd1);

    // Single word, n=10, plus an ignored MID word driven while ready is low.
    $display("[TB] single word frame");
    d0 = done_total; e0 = err_total;
    applyStimulus(mkWord(2'b00, 4'd10, 8'h10), 0, 1'b0, t);
    r = -1;
    for (int w = 0; w < 200; w++) begin
      @(negedge i_clk);
      if (sif.o_pkt_data_ready) begin
        r = cyc;
        break;
      end
      sif.iv_pkt_data = mkWord(2'b11, 4'd0, 8'hEE);
      sif.i_pkt_data_wr = (cyc >= t + 20) && (cyc <= t + 24);
    end
    sif.i_pkt_data_wr = 1'b0;
    checkOutput("first_byte_cycle", 64'(first_byte_cyc), 64'(t + 1));
    checkOutput("done_cycle", 64'(done_cyc), 64'(t + 14));
    checkOutput("ready_cycle", 64'(r), 64'(t + 27));
    checkOutput("single_done_count", 64'(done_total - d0), 64'd1);
    checkOutput("not_ready_wr_ignored", 64'(err_total - e0), 64'd0);
    waitIdle();

    $display("[TB] four word frame back to back");
    d0 = done_total; g0 = gap_total;
    applyStimulus(mkWord(2'b01, 4'd0, 8'h20), 0, 1'b0, t);
    applyStimulus(mkWord(2'b11, 4'd0, 8'h30), 0, 1'b0, r);
    applyStimulus(mkWord(2'b11, 4'd0, 8'h40), 0, 1'b0, r);
    applyStimulus(mkWord(2'b10, 4'd0, 8'h50), 0, 1'b0, r);
    waitIdle();
    checkOutput("b2b_span", 64'(last_byte_cyc - first_byte_cyc), 64'd71);
    checkOutput("b2b_gaps", 64'(gap_total - g0), 64'd0);
    checkOutput("b2b_done_count", 64'(done_total - d0), 64'd1);

    $display("[TB] upstream stalls");
    d0 = done_total; g0 = gap_total; s0 = stall_total;
    applyStimulus(mkWord(2'b01, 4'd0, 8'h60), 0, 1'b0, t);
    applyStimulus(mkWord(2'b11, 4'd0, 8'h70), 3, 1'b0, r);
    applyStimulus(mkWord(2'b10, 4'd4, 8'h80), 2, 1'b0, r);
    waitIdle();
    checkOutput("stall_gaps", 64'(gap_total - g0), 64'd5);
    checkOutput("stall_pulse_count", 64'(stall_total - s0), 64'd1);
    checkOutput("stall_done_count", 64'(done_total - d0), 64'd1);

    $display("[TB] middle word in idle, then one-byte tail");
    d0 = done_total; e0 = err_total;
    applyStimulus(mkWord(2'b11, 4'd0, 8'h33), 0, 1'b1, t);
    repeat (4) @(negedge i_clk);
    checkOutput("idle_mid_err", 64'(err_total - e0), 64'd1);
    applyStimulus(mkWord(2'b01, 4'd0, 8'hC0), 0, 1'b0, t);
    applyStimulus(mkWord(2'b10, 4'd15, 8'h7A), 0, 1'b0, r);
    waitIdle();
    checkOutput("short_tail_done", 64'(done_total - d0), 64'd1);
    checkOutput("short_tail_err", 64'(err_total - e0), 64'd1);

    $display("[TB] head inside a frame");
    d0 = done_total; e0 = err_total;
    applyStimulus(mkWord(2'b01, 4'd0, 8'h90), 0, 1'b0, t);
    applyStimulus(mkWord(2'b01, 4'd0, 8'hA0), 0, 1'b1, r);
    waitReady(r);
    checkOutput("trunc_ready_cycle", 64'(r), 64'(last_byte_cyc + IFG + 1));
    checkOutput("trunc_err", 64'(err_total - e0), 64'd1);
    checkOutput("trunc_no_done", 64'(done_total - d0), 64'd0);
    checkOutput("trunc_drained", 64'(sb.size()), 64'd0);

    $display("[TB] reset in mid payload");
    d0 = done_total;
    applyStimulus(mkWord(2'b01, 4'd0, 8'hB0), 0, 1'b0, t);
    repeat (11) @(negedge i_clk);
    checkOutput("pre_reset_wr", 64'(sif.o_pkt_data_wr), 64'd1);
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1 checkQuiet("async_reset");
    sb.delete();
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    applyStimulus(mkWord(2'b01, 4'd0, 8'hC8), 0, 1'b0, t);
    applyStimulus(mkWord(2'b10, 4'd8, 8'hD8), 0, 1'b0, r);
    waitIdle();
    checkOutput("post_reset_done", 64'(done_total - d0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
